// File: rtl/wb_uart.sv
// Wishbone classic slave UART (8N1): TX FIFO feeding a serialiser, RX deserialiser
// into a one-byte holding register, four-word register window on adr[3:2].
`timescale 1ns/1ps
module wb_uart #(
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);
    localparam int AW = $clog2(TX_DEPTH);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    logic        ack_q, ack_d, err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] div_q, div_d, div_new;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [TX_DEPTH];
    logic        tx_ovf_q, tx_ovf_d;
    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d;

    logic        req, wr_req, rd_req, data_rd, stat_rd, push_req, push, pop, start_frame;
    logic        tx_full, tx_empty, tx_busy, rx_fall, rx_set, frm_set;
    logic [1:0]  adr;
    logic [31:0] status;
    logic        unused_bits;

    assign adr      = wb_adr_i[3:2];
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wr_req   = req & wb_we_i;
    assign rd_req   = req & ~wb_we_i;
    assign data_rd  = rd_req & (adr == 2'd0);
    assign stat_rd  = rd_req & (adr == 2'd1);
    assign push_req = wr_req & (adr == 2'd0) & wb_sel_i[0];
    assign tx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_empty = (wr_ptr_q == rd_ptr_q);
    // A full FIFO rejects the push even if the serialiser pops in the same cycle.
    assign push     = push_req & ~tx_full;
    assign tx_busy  = (tx_state_q != TX_IDLE);
    assign rx_fall  = rx_prev_q & ~rx_s2_q;
    assign status   = {25'b0, frm_err_q, tx_ovf_q, tx_busy, rx_ovr_q, rx_valid_q, tx_empty, tx_full};
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    always_comb begin : bus_next
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ack_d   = req & (adr != 2'd3);
        err_d   = req & (adr == 2'd3);
        dat_d   = '0;
        div_new = div_q;
        div_d   = div_q;
        if (rd_req) begin
            case (adr)
                2'd0:    dat_d = rx_valid_q ? {24'b0, rx_byte_q} : 32'd0;
                2'd1:    dat_d = status;
                2'd2:    dat_d = {16'b0, div_q};
                default: dat_d = '0;
            endcase
        end
        if (wr_req && adr == 2'd2) begin
            if (wb_sel_i[0]) div_new[7:0]  = wb_dat_i[7:0];
            if (wb_sel_i[1]) div_new[15:8] = wb_dat_i[15:8];
            div_d = (div_new < 16'd3) ? 16'd3 : div_new;
        end
        tx_ovf_d = (push_req & tx_full) | (tx_ovf_q & ~stat_rd);
    end

    always_comb begin : tx_next
        tx_state_d  = tx_state_q;
        tx_div_d    = tx_div_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        start_frame = 1'b0;
        pop         = 1'b0;
        case (tx_state_q)
            TX_IDLE:  start_frame = ~tx_empty;
            TX_START: if (tx_cnt_q == 16'd0) begin
                          tx_state_d = TX_DATA;
                          tx_cnt_d   = tx_div_q;
                          tx_bit_d   = 3'd0;
                      end else tx_cnt_d = tx_cnt_q - 16'd1;
            TX_DATA:  if (tx_cnt_q == 16'd0) begin
                          tx_cnt_d = tx_div_q;
                          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                          else                  tx_bit_d   = tx_bit_q + 3'd1;
                      end else tx_cnt_d = tx_cnt_q - 16'd1;
            TX_STOP:  if (tx_cnt_q == 16'd0) begin
                          if (tx_empty) tx_state_d  = TX_IDLE;
                          else          start_frame = 1'b1;
                      end else tx_cnt_d = tx_cnt_q - 16'd1;
            default:  tx_state_d = TX_IDLE;
        endcase
        // DIV is captured per frame so a mid-frame DIV write only affects the next start.
        if (start_frame) begin
            pop        = 1'b1;
            tx_state_d = TX_START;
            tx_div_d   = div_q;
            tx_cnt_d   = div_q;
            tx_sh_d    = mem_q[rd_ptr_q[AW-1:0]];
        end
        tx_d     = (tx_state_d == TX_START) ? 1'b0 : (tx_state_d == TX_DATA) ? tx_sh_d[0] : 1'b1;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_comb begin : rx_next
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_set     = 1'b0;
        frm_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall) begin
                          rx_state_d = RX_START;
                          rx_div_d   = div_q;
                          rx_cnt_d   = div_q >> 1;
                      end
            RX_START: if (rx_cnt_q == 16'd0) begin
                          if (rx_s2_q) rx_state_d = RX_IDLE;
                          else begin
                              rx_state_d = RX_DATA;
                              rx_cnt_d   = rx_div_q;
                              rx_bit_d   = 3'd0;
                          end
                      end else rx_cnt_d = rx_cnt_q - 16'd1;
            RX_DATA:  if (rx_cnt_q == 16'd0) begin
                          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                          rx_cnt_d = rx_div_q;
                          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                          else                  rx_bit_d   = rx_bit_q + 3'd1;
                      end else rx_cnt_d = rx_cnt_q - 16'd1;
            RX_STOP:  if (rx_cnt_q == 16'd0) begin
                          if (rx_s2_q) begin
                              rx_set     = 1'b1;
                              rx_byte_d  = rx_sh_q;
                              rx_state_d = RX_IDLE;
                          end else begin
                              frm_set    = 1'b1;
                              rx_state_d = RX_WAIT;
                          end
                      end else rx_cnt_d = rx_cnt_q - 16'd1;
            RX_WAIT:  if (rx_s2_q) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
        // Hardware sets win over clear-on-read in the same cycle.
        rx_valid_d = rx_set | (rx_valid_q & ~data_rd);
        rx_ovr_d   = (rx_set & rx_valid_q) | (rx_ovr_q & ~stat_rd);
        frm_err_d  = frm_set | (frm_err_q & ~stat_rd);
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            div_q      <= DIV_RESET;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_ovf_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_div_q   <= '0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            div_q      <= div_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_ovf_q   <= tx_ovf_d;
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            rx_s1_q    <= uart_rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wb_dat_i[7:0];
    end

    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_dat_o  = dat_q;
    assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: bus scoreboard, serial-line TX decoder and an RX
// line driver, all against a register-level reference model of the UART.
`timescale 1ns/1ps
module tb_wb_uart;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, uart_tx_o;
    logic        uart_rx_i = 1'b1;

    always #5 clk = ~clk;

    wb_uart #(.TX_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference model state
    logic [15:0] m_div = 16'd433;
    bit          m_valid, m_ovr, m_ovf, m_frm;
    logic [7:0]  m_byte;
    int          accepted = 0, started = 0;
    bit          in_frame = 1'b0;
    logic [7:0]  tx_exp[$];

    typedef struct {
        string       name;
        bit          err;
        logic [31:0] dat;
    } bus_exp_t;
    bus_exp_t bus_q[$];
    bus_exp_t be;

    function automatic logic [31:0] model_status();
        int occ;
        occ = accepted - started;
        return {25'b0, m_frm, m_ovf, in_frame, m_ovr, m_valid, occ == 0, occ == DEPTH};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Bus scoreboard monitor: pops one expectation per response.
    always @(negedge clk) begin
        if (wb_ack_o || wb_err_o) begin
            if (bus_q.size() == 0) fail_now("bus_unexpected", "response with no pending request");
            else begin
                be = bus_q.pop_front();
                check({be.name, " resp"}, {30'b0, wb_ack_o, wb_err_o}, {30'b0, !be.err, be.err});
                check({be.name, " rdata"}, wb_dat_o, be.dat);
            end
        end
    end

    // Serial TX decoder: checks every cycle of each frame against the expected byte.
    int         k, p, bad, slot;
    logic [7:0] cur;
    logic       expb;

    task automatic start_frame();
        if (tx_exp.size() == 0) begin
            fail_now("tx_unexpected", "start bit with no byte queued");
            cur = 8'h00;
        end else cur = tx_exp.pop_front();
        started++;
        p = int'(m_div) + 1;
        in_frame = 1'b1;
        k = 1;
        bad = 0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) in_frame = 1'b0;
        else if (in_frame) begin
            if (k < 10 * p) begin
                slot = k / p;
                expb = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : cur[slot-1];
                if (uart_tx_o !== expb) bad++;
                k++;
            end else begin
                check($sformatf("tx_frame 0x%02h bad_cycles", cur), bad, 0);
                if (accepted > started) check("tx_no_gap", uart_tx_o, 1'b0);
                if (uart_tx_o == 1'b0) start_frame();
                else in_frame = 1'b0;
            end
        end else if (uart_tx_o == 1'b0) start_frame();
    end

    task automatic bus(input bit we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] sel,
                       input bit exp_err, input logic [31:0] exp_dat, input string name, input bit is_push);
        int n;
        bus_exp_t e;
        e.name = name; e.err = exp_err; e.dat = exp_dat;
        bus_q.push_back(e);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {28'h0, a}; wb_dat_i = d; wb_sel_i = sel;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 8);
        check({name, " latency"}, n, 1);
        if (wb_ack_o && is_push) begin
            tx_exp.push_back(d[7:0]);
            accepted++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wait_cyc(1);
    endtask

    task automatic wr_data(input logic [7:0] b, input logic [3:0] sel);
        bit          ok;
        logic [31:0] d;
        ok = sel[0] && ((accepted - started) < DEPTH);
        d = $urandom;
        d[7:0] = b;
        bus(1'b1, 4'h0, d, sel, 1'b0, 32'h0, "wr_data", ok);
        if (sel[0] && !ok) m_ovf = 1'b1;
    endtask

    task automatic rd_status();
        logic [31:0] e;
        e = model_status();
        bus(1'b0, 4'h4, $urandom, 4'hF, 1'b0, e, "rd_status", 1'b0);
        m_ovr = 1'b0; m_ovf = 1'b0; m_frm = 1'b0;
    endtask

    task automatic rd_data();
        logic [31:0] e;
        e = m_valid ? {24'b0, m_byte} : 32'h0;
        bus(1'b0, 4'h0, $urandom, 4'hF, 1'b0, e, "rd_data", 1'b0);
        m_valid = 1'b0;
    endtask

    task automatic wr_div(input logic [15:0] v, input logic [3:0] sel);
        logic [15:0] nd;
        nd = m_div;
        if (sel[0]) nd[7:0]  = v[7:0];
        if (sel[1]) nd[15:8] = v[15:8];
        if (nd < 16'd3) nd = 16'd3;
        bus(1'b1, 4'h8, {16'hA5A5, v}, sel, 1'b0, 32'h0, "wr_div", 1'b0);
        m_div = nd;
    endtask

    task automatic rd_div();
        bus(1'b0, 4'h8, $urandom, 4'hF, 1'b0, {16'h0, m_div}, "rd_div", 1'b0);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        int pp;
        pp = int'(m_div) + 1;
        uart_rx_i = 1'b0;
        wait_cyc(pp);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            wait_cyc(pp);
        end
        uart_rx_i = stop;
        wait_cyc(pp);
        uart_rx_i = 1'b1;
        wait_cyc(2 * pp + 4);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_byte  = b;
        end else m_frm = 1'b1;
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while ((in_frame || accepted != started) && n < 5000) begin
            wait_cyc(1);
            n++;
        end
        check("tx_drain_bound", {31'b0, n < 5000}, 32'd1);
    endtask

    task automatic model_reset();
        m_div = 16'd433;
        m_valid = 1'b0; m_ovr = 1'b0; m_ovf = 1'b0; m_frm = 1'b0;
        accepted = 0; started = 0;
        tx_exp.delete();
    endtask

    initial begin
        int op;
        // Reset state and register defaults
        model_reset();
        wait_cyc(3);
        check("tx_in_reset", uart_tx_o, 1'b1);
        rst_n = 1'b1;
        wait_cyc(1);
        rd_status();
        rd_div();
        check("tx_idle", uart_tx_o, 1'b1);

        // Single frame, exact waveform, busy during the frame
        wr_div(16'd9, 4'h3);
        rd_div();
        wr_data(8'h55, 4'h1);
        wait_cyc(20);
        rd_status();
        wait_tx_idle();

        // FIFO fill with overflow, back-to-back frames
        for (int i = 0; i < 6; i++) wr_data(8'hC0 + 8'(i), 4'h1);
        rd_status();
        rd_status();
        wait_tx_idle();

        // RX byte, clear on read, overrun keeps the latest byte
        send_rx(8'hA3, 1'b1);
        rd_status();
        rd_data();
        rd_status();
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC5, 1'b1);
        rd_status();
        rd_data();

        // Framing error and false-start glitch
        send_rx(8'h81, 1'b0);
        rd_status();
        rd_data();
        uart_rx_i = 1'b0;
        wait_cyc(3);
        uart_rx_i = 1'b1;
        wait_cyc(30);
        rd_status();

        // Unmapped address, DIV clamp, byte-select gating
        bus(1'b1, 4'hC, 32'h0000_0077, 4'hF, 1'b1, 32'h0, "wr_unmapped", 1'b0);
        bus(1'b0, 4'hC, 32'h0, 4'hF, 1'b1, 32'h0, "rd_unmapped", 1'b0);
        rd_status();
        wr_div(16'd1, 4'h3);
        rd_div();
        wr_div(16'd9, 4'h1);
        rd_div();
        wr_data(8'h12, 4'h2);
        rd_status();

        // Randomised mix
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: wr_data(8'($urandom), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'h1);
                1: rd_status();
                2: rd_data();
                3: send_rx(8'($urandom), $urandom_range(0, 9) != 0);
                4: rd_div();
                default: begin
                    if (!in_frame && accepted == started)
                        wr_div(16'($urandom_range(0, 12)), 4'($urandom_range(0, 3)));
                    else rd_status();
                end
            endcase
        end
        wait_tx_idle();
        rd_status();

        // Reset in mid-frame
        wr_div(16'd9, 4'h3);
        wr_data(8'h00, 4'h1);
        wr_data(8'h00, 4'h1);
        wait_cyc(25);
        check("tx_before_reset", uart_tx_o, 1'b0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("tx_after_reset", uart_tx_o, 1'b1);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);
        rd_status();
        rd_div();
        wait_cyc(40);
        check("tx_stays_idle", uart_tx_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
